// File: rtl/cbus_mem_responder.sv
// Cache-bus memory responder: serves single-beat and burst cbus reads/writes
// from an internal 64-bit word array after a fixed first-beat latency.

package cbus_pkg;
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [3:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module cbus_mem_responder
  import cbus_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, COOL} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [3:0]      len_q, len_d;
  logic [3:0]      beat_q, beat_d;
  logic [3:0]      lat_q, lat_d;
  logic [1:0]      burst_q, burst_d;
  logic            write_q, write_d;
  logic            ready_q, ready_d;
  logic            last_q, last_d;

  logic [63:0]     mem [MEM_WORDS];

  logic [63:0]     offset;
  logic [AW-1:0]   req_idx;
  logic [AW-1:0]   idx_inc;
  logic [AW-1:0]   wrap_mask;
  logic [AW-1:0]   next_idx;
  logic            unused_bits;

  assign offset      = creq.addr - BASE_ADDR;
  assign req_idx     = offset[AW+2:3];
  assign idx_inc     = idx_q + AW'(1);
  assign wrap_mask   = AW'(len_q);
  assign unused_bits = ^{creq.size, offset[2:0], offset[63:AW+3]};

  // WRAP keeps the upper index bits and rolls the low bits within a len+1 block.
  always_comb begin
    next_idx = idx_q;
    case (burst_q)
      BURST_INCR: next_idx = idx_inc;
      BURST_WRAP: next_idx = (idx_q & ~wrap_mask) | (idx_inc & wrap_mask);
      default:    next_idx = idx_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    burst_d = burst_q;
    write_d = write_q;
    case (state_q)
      IDLE: begin
        if (creq.valid) begin
          idx_d   = req_idx;
          len_d   = creq.len;
          write_d = creq.is_write;
          burst_d = creq.burst;
          beat_d  = 4'd0;
          lat_d   = 4'(LATENCY);
          state_d = (LATENCY == 0) ? BURST : WAIT;
        end
      end
      WAIT: begin
        if (!creq.valid)      state_d = IDLE;
        else if (lat_q <= 4'd1) state_d = BURST;
        else                  lat_d = lat_q - 4'd1;
      end
      BURST: begin
        if (!creq.valid) begin
          state_d = IDLE;
        end else begin
          idx_d  = next_idx;
          beat_d = beat_q + 4'd1;
          if (beat_q == len_q) state_d = COOL;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == BURST);
    last_d  = (state_d == BURST) && (beat_d == len_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
      burst_q <= '0;
      write_q <= 1'b0;
      ready_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      burst_q <= burst_d;
      write_q <= write_d;
      ready_q <= ready_d;
      last_q  <= last_d;
    end
  end

  // Memory is deliberately left out of reset so contents survive an abort.
  always_ff @(posedge clk) begin
    if (state_q == BURST && write_q && creq.valid) begin
      for (int i = 0; i < 8; i++) begin
        if (creq.strobe[i]) mem[idx_q][8*i +: 8] <= creq.data[8*i +: 8];
      end
    end
  end

  always_comb begin
    cresp.ready = ready_q;
    cresp.last  = last_q;
    cresp.data  = (state_q == BURST && !write_q) ? mem[idx_q] : 64'd0;
  end

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Self-checking bench for cbus_mem_responder: directed protocol scenarios plus
// randomized bursts compared against a word-array reference model.

module tb_cbus_mem_responder;
  import cbus_pkg::*;

  localparam int unsigned MEM_WORDS = 4096;
  localparam int unsigned LATENCY   = 2;
  localparam logic [63:0] BASE      = 64'h8000_0000;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  int checks = 0;
  int passed = 0;

  logic [63:0] model_mem [MEM_WORDS];
  logic [63:0] wdata [16];
  logic [7:0]  wstrb [16];

  always #5 clk = ~clk;

  cbus_mem_responder #(
    .MEM_WORDS(MEM_WORDS),
    .LATENCY  (LATENCY),
    .BASE_ADDR(BASE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .creq (creq),
    .cresp(cresp)
  );

  function automatic int addr_to_idx(input logic [63:0] addr);
    logic [63:0] w;
    w = ((addr - BASE) >> 3) % MEM_WORDS;
    return int'(w);
  endfunction

  // Word visited on beat b, from the burst rules stated as arithmetic.
  function automatic int beat_idx(input int start, input int len, input logic [1:0] burst, input int b);
    int blk;
    case (burst)
      BURST_INCR: return (start + b) % MEM_WORDS;
      BURST_WRAP: begin
        blk = len + 1;
        return start - (start % blk) + ((start % blk) + b) % blk;
      end
      default:    return start;
    endcase
  endfunction

  // Runs one transaction starting in an IDLE cycle; ends in the next IDLE cycle.
  task automatic run_txn(input string name, input bit wr, input logic [63:0] addr,
                         input int len, input logic [1:0] burst, input bit hold);
    int start;
    int idx;
    logic [63:0] exp;
    start = addr_to_idx(addr);
    creq.valid    = 1'b1;
    creq.is_write = wr;
    creq.size     = 3'd3;
    creq.addr     = addr;
    creq.len      = len[3:0];
    creq.burst    = burst;
    creq.data     = wdata[0];
    creq.strobe   = wstrb[0];
    @(posedge clk); #1;
    for (int k = 1; k <= LATENCY; k++) begin
      checks++;
      if (cresp.ready !== 1'b0 || cresp.last !== 1'b0 || cresp.data !== 64'd0)
        $display("[TB] FAIL %s wait%0d: ready=%b last=%b data=%h, want ready=0 last=0 data=0",
                 name, k, cresp.ready, cresp.last, cresp.data);
      else passed++;
      @(posedge clk); #1;
    end
    for (int b = 0; b <= len; b++) begin
      idx = beat_idx(start, len, burst, b);
      exp = wr ? 64'd0 : model_mem[idx];
      checks++;
      if (cresp.ready !== 1'b1 || cresp.last !== (b == len) || cresp.data !== exp)
        $display("[TB] FAIL %s beat%0d: ready=%b last=%b data=%h, want ready=1 last=%b data=%h",
                 name, b, cresp.ready, cresp.last, cresp.data, (b == len), exp);
      else passed++;
      if (wr) begin
        for (int i = 0; i < 8; i++)
          if (creq.strobe[i]) model_mem[idx][8*i +: 8] = creq.data[8*i +: 8];
      end
      @(posedge clk); #1;
      if (b < len) begin
        creq.data   = wdata[b+1];
        creq.strobe = wstrb[b+1];
      end
    end
    checks++;
    if (cresp.ready !== 1'b0 || cresp.last !== 1'b0 || cresp.data !== 64'd0)
      $display("[TB] FAIL %s cool: ready=%b last=%b data=%h, want ready=0 last=0 data=0",
               name, cresp.ready, cresp.last, cresp.data);
    else passed++;
    if (!hold) creq.valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    creq  = '0;
    reset = 1'b1;
    #1;
    checks++;
    if (cresp.ready !== 1'b0 || cresp.last !== 1'b0 || cresp.data !== 64'd0)
      $display("[TB] FAIL reset: ready=%b last=%b data=%h, want all 0",
               cresp.ready, cresp.last, cresp.data);
    else passed++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_single_write_read();
    wdata[0] = 64'h1122334455667788;
    wstrb[0] = 8'hFF;
    run_txn("single_wr", 1'b1, BASE + 64'h10, 0, BURST_INCR, 1'b0);
    run_txn("single_rd", 1'b0, BASE + 64'h10, 0, BURST_INCR, 1'b0);
  endtask

  task automatic test_partial_write();
    wdata[0] = 64'hAAAAAAAA_BBBBBBBB;
    wstrb[0] = 8'h0F;
    run_txn("partial_wr", 1'b1, BASE + 64'h10, 0, BURST_INCR, 1'b0);
    checks++;
    if (model_mem[2] !== 64'h11223344_BBBBBBBB)
      $display("[TB] FAIL partial_model: got %h, want %h", model_mem[2], 64'h11223344_BBBBBBBB);
    else passed++;
    run_txn("partial_rd", 1'b0, BASE + 64'h10, 0, BURST_INCR, 1'b0);
  endtask

  task automatic test_incr_burst();
    wstrb[0] = 8'hFF;
    for (int w = 0; w < 4; w++) begin
      wdata[0] = 64'(w);
      run_txn("incr_wr", 1'b1, BASE + 64'(w * 8), 0, BURST_INCR, 1'b0);
    end
    run_txn("incr_rd", 1'b0, BASE, 3, BURST_INCR, 1'b0);
  endtask

  task automatic test_wrap_burst();
    run_txn("wrap_rd", 1'b0, BASE + 64'h10, 3, BURST_WRAP, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_first",  1'b0, BASE,        3, BURST_INCR, 1'b1);
    run_txn("b2b_second", 1'b0, BASE + 64'h8, 1, BURST_INCR, 1'b0);
  endtask

  task automatic test_reset_mid();
    creq.valid    = 1'b1;
    creq.is_write = 1'b0;
    creq.addr     = BASE;
    creq.len      = 4'd7;
    creq.burst    = BURST_INCR;
    @(posedge clk); #1;
    repeat (LATENCY) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    checks++;
    if (cresp.ready !== 1'b1 || cresp.data !== model_mem[1])
      $display("[TB] FAIL mid_beat2: ready=%b data=%h, want ready=1 data=%h",
               cresp.ready, cresp.data, model_mem[1]);
    else passed++;
    reset = 1'b1;
    #1;
    checks++;
    if (cresp.ready !== 1'b0 || cresp.last !== 1'b0 || cresp.data !== 64'd0)
      $display("[TB] FAIL mid_reset: ready=%b last=%b data=%h, want all 0",
               cresp.ready, cresp.last, cresp.data);
    else passed++;
    creq.valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    run_txn("after_reset", 1'b0, BASE, 0, BURST_INCR, 1'b0);
  endtask

  task automatic test_valid_drop();
    creq.valid    = 1'b1;
    creq.is_write = 1'b1;
    creq.addr     = BASE + 64'(40 * 8);
    creq.len      = 4'd3;
    creq.burst    = BURST_INCR;
    @(posedge clk); #1;
    creq.valid = 1'b0;
    for (int k = 0; k < LATENCY + 2; k++) begin
      @(posedge clk); #1;
      checks++;
      if (cresp.ready !== 1'b0)
        $display("[TB] FAIL drop_idle%0d: ready=%b, want 0", k, cresp.ready);
      else passed++;
    end
    run_txn("drop_recover", 1'b0, BASE + 64'h10, 0, BURST_FIXED, 1'b0);
  endtask

  task automatic test_random();
    int len, start, bsel;
    logic [1:0] burst;
    logic [63:0] addr;
    int wrap_lens [5] = '{0, 1, 3, 7, 15};
    for (int i = 0; i < 16; i++) begin
      wdata[i] = {$urandom, $urandom};
      wstrb[i] = 8'hFF;
    end
    run_txn("fill_lo", 1'b1, BASE,              15, BURST_INCR, 1'b0);
    for (int i = 0; i < 16; i++) wdata[i] = {$urandom, $urandom};
    run_txn("fill_hi", 1'b1, BASE + 64'(16 * 8), 15, BURST_INCR, 1'b0);
    for (int t = 0; t < 24; t++) begin
      bsel = int'($urandom_range(0, 2));
      if (bsel == 2) begin
        burst = BURST_WRAP;
        len   = wrap_lens[$urandom_range(0, 4)];
        start = int'($urandom_range(0, 31));
      end else if (bsel == 1) begin
        burst = BURST_INCR;
        len   = int'($urandom_range(0, 15));
        start = int'($urandom_range(0, 31 - len));
      end else begin
        burst = BURST_FIXED;
        len   = int'($urandom_range(0, 15));
        start = int'($urandom_range(0, 31));
      end
      for (int i = 0; i < 16; i++) begin
        wdata[i] = {$urandom, $urandom};
        wstrb[i] = 8'($urandom);
      end
      addr = BASE + 64'(start * 8) + 64'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) addr = addr + 64'(MEM_WORDS * 8);
      run_txn("random", bit'($urandom_range(0, 1)), addr, len, burst,
              (t != 23) && ($urandom_range(0, 1) == 1));
    end
  endtask

  initial begin
    test_reset();
    test_single_write_read();
    test_partial_write();
    test_incr_burst();
    test_wrap_burst();
    test_back_to_back();
    test_reset_mid();
    test_valid_drop();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cbus_mem_responder.md
Name: cbus_mem_responder

Overview:
Cache-bus (cbus) responder: the memory side of the cbus protocol that the cache initiates. It accepts single-beat and burst read/write requests and serves them from an internal 64-bit-word memory array after a configurable first-beat latency. It is the simulation and standalone memory target for the ICache/DCache path and replaces the external bus bridge in block-level benches.

Parameters:
MEM_WORDS, 4096, number of 64-bit words in the array; power of two.
LATENCY, 2, idle cycles between request acceptance and the first data beat; range 0..15.
BASE_ADDR, 64'h8000_0000, byte address mapped to word 0.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
creq  input  cbus_req_t  request struct:
  - valid, is_write, size[2:0], addr[63:0], strobe[7:0], data[63:0], len[3:0] (beats-1), burst[1:0] (FIXED/INCR/WRAP).
cresp  output  cbus_resp_t  response struct:
  - ready (beat handshake), last (final beat), data[63:0] (read data).

Behaviour:
- Reset (async, reset=1): state=IDLE; cresp.ready=0, cresp.last=0, cresp.data=0 immediately. Memory contents are not cleared.
- Word index: idx = ((addr - BASE_ADDR) >> 3) mod MEM_WORDS. Out-of-range addresses alias silently; no error.
- FSM has four states: IDLE, WAIT, BURST, COOL.
- IDLE:
  - If creq.valid=1, latch idx, len, is_write, burst; beat counter=0; latency counter=LATENCY.
  - Next state is WAIT if LATENCY>0, else BURST.
- WAIT: decrement the counter each cycle. Enter BURST on the cycle after the counter reaches 1, so the first beat appears LATENCY+1 cycles after acceptance.
- BURST:
  - cresp.ready=1 every cycle (one beat per cycle, no bubbles).
  - cresp.last = (beat == latched len).
  - Read: cresp.data = mem[idx], combinational from the current idx. Write: at the clock edge, mem[idx] byte i <= creq.data byte i for each strobe[i]=1.
  - Write data and strobe are sampled per beat. The initiator presents the next beat's data after seeing ready.
  - Address advance per beat:
    - FIXED: idx unchanged.
    - INCR: idx+1 mod MEM_WORDS.
    - WRAP: low log2(len+1) bits of idx increment modulo len+1; upper bits fixed. WRAP is defined for len in {0,1,3,7,15} only.
  - On the last beat, go to COOL.
- COOL: one cycle with ready=0. creq.valid is ignored, because the initiator may still hold valid in the cycle after ready&last. Then go to IDLE.
- cresp.data = 0 whenever state != BURST or is_write=1.
- creq.valid dropping in WAIT/BURST is a protocol violation: abort to IDLE next cycle. Writes already performed stay committed.
- A request held valid through COOL is accepted in IDLE as a new transaction (back-to-back requests).
- size is ignored; strobe alone governs write byte enables.
- Reset asserted mid-transaction aborts it; the next request after reset release is serviced normally.

Test Plan:
- LATENCY=2, write len=0, INCR, addr BASE+0x10, data 64'h1122334455667788, strobe 8'hFF -> ready=last=1 exactly 3 cycles after valid was sampled in IDLE. A following read of the same address returns 64'h1122334455667788 with last=1.
- Partial write to BASE+0x10, strobe 8'h0F, data 64'hAAAAAAAA_BBBBBBBB -> read returns 64'h11223344_BBBBBBBB.
- Write words 0..3 with values 0,1,2,3, then INCR read len=3 at BASE -> 4 consecutive ready beats with data 0,1,2,3; last only on the 4th; ready=0 in the following (COOL) cycle.
- WRAP read len=3 at BASE+0x10 (word 2) -> beat data order 2,3,0,1; last on beat 4.
- Valid held high continuously across two INCR read requests -> exactly one ready=0 COOL cycle between transactions; the second transaction's first beat appears LATENCY+1 cycles after its acceptance in IDLE.
- Assert reset during beat 2 of a len=7 read -> ready/last/data drop to 0 in the same cycle without a clock edge. After release, a len=0 read of word 0 returns the previously written value 0.
